sha256_msg_pad: RTL
===================

Name: sha256_msg_pad

Overview:
- Streaming SHA-256 message padder. Sits between a 32-bit message source and the sha256 core's buffer-data input.
- Accepts raw message words with a last flag and a valid-byte count.
- Emits complete 512-bit blocks as 16 big-endian 32-bit words per FIPS 180-4: 0x80 marker, zero fill, then the 64-bit bit-length.
- Replaces hand-fed buffer data and supports arbitrary message lengths.

Parameters:
- LEN_W, 64, width of the internal bit-length counter (8..64). Zero-extended into the 64-bit length field.
- BLK_CNT_W, 16, width of the per-message emitted-block counter.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- in_vld  in  1  input word valid
- in_rdy  out  1  padder can accept an input word
- in_data  in  32  message word, byte 0 in [31:24]
- in_last  in  1  final word of the message
- in_nbytes  in  3  valid bytes in the last word (0..4). Ignored, treated as 4, when in_last=0.
- out_vld  out  1  output word valid
- out_rdy  in  1  sink accepts the output word
- out_data  out  32  padded block word
- out_blk_first  out  1  word index 0 of a block
- out_blk_last  out  1  word index 15 of a block
- out_msg_last  out  1  final word of the final block
- blk_cnt  out  BLK_CNT_W  blocks completed in the current message
- len_ovf  out  1  sticky: bit length exceeded 2^LEN_W-1

Behaviour:
- Reset (async, any state): state=DATA, idx=0, len=0, blk_cnt=0, out_vld=0, out_data=0, all flags 0, len_ovf=0.
- Output stage:
  - Single output register, 1-cycle latency from the accepted input to out_vld.
  - Out regs load when `adv = !out_vld | out_rdy`.
  - While out_vld=1 and out_rdy=0, out_data and all flags hold stable.
- Input acceptance: `in_rdy = (state==DATA) & adv`. An input word is accepted when `in_vld & in_rdy`.
- Word index idx (4 bits):
  - Increments on every emitted word (load into out reg) and wraps 15→0.
  - out_blk_first = (idx==0); out_blk_last = (idx==15).
  - blk_cnt increments when an idx==15 word is emitted; it saturates at its maximum.
- Length: len += 8*nbytes per accepted word (32 for non-last words). If the sum would overflow LEN_W, len saturates and len_ovf is set.
- States:
  - DATA
    - Non-last word: emit in_data unchanged.
    - Last word with n = in_nbytes:
      - n=1..3: emit the word with bytes ≥n masked to 0 and 0x80 placed in byte n. Next state per PAD_NEXT.
      - n=4: emit the word as-is. Next state PAD80.
      - n=0: emit 0x80000000. Next state per PAD_NEXT.
  - PAD80: emit 0x80000000. Next state per PAD_NEXT.
  - PAD_NEXT rule: after the pad-carrying word, go to LEN_HI if the new idx==14, else ZERO.
  - ZERO: emit 0x00000000. After the emit, go to LEN_HI when the new idx==14.
    - A pad word at idx 14 or 15 therefore forces an extra block.
  - LEN_HI: emit len[63:32] (zero-extended).
  - LEN_LO: emit len[31:0] with out_msg_last=1.
    - On emit: len=0, blk_cnt=0, idx=0 (already wrapped), state=DATA.
  - len_ovf is cleared only by reset.
  - Only DATA consumes input. PAD80, ZERO, LEN_HI and LEN_LO advance only when adv=1.
- A new message may be accepted on the cycle after the LEN_LO word is loaded. There are no bubbles other than those caused by back-pressure.
- Reset mid-message drops all partial state. The sink must discard any partial block.

Optional Feature:
- Macro SHA256_PAD_BSWAP_EN.
- Defined: in_data is little-endian (byte 0 in [7:0]). Each accepted word is byte-swapped before masking and padding, so out_data is identical to the big-endian case for the same byte stream. in_nbytes keeps the same meaning.
- Undefined: no swap; in_data is big-endian as specified above.

Test Plan:
- Empty message: in_last=1, in_nbytes=0.
  - Expect exactly 16 words: 0x80000000, 13×0, 0x00000000, 0x00000000.
  - out_msg_last on word 15; blk_cnt reaches 1, then returns to 0.
- "abc": in_data=0x61626300, in_last=1, nbytes=3.
  - Expect word0 0x61626380, words 1..14 zero, word15 0x00000018.
  - Feeding this to sha256 gives digest ba7816bf...f20015ad.
- 14 full words with word13 last, nbytes=4.
  - Expect 14 data words, then 0x80000000 at idx14, 0 at idx15.
  - Second block: idx0..13 zero, LEN_HI 0, LEN_LO 0x000001C0. 32 words total; blk_cnt reaches 2.
- Back-pressure: toggle out_rdy randomly during the "abc" case.
  - out_data and flags stay stable while out_vld & !out_rdy.
  - in_rdy=0 whenever out_vld & !out_rdy; word sequence unchanged.
- Assert rst mid-ZERO in a 2-block message.
  - out_vld drops asynchronously, idx/len/blk_cnt are 0.
  - The next "abc" message pads correctly.
- LEN_W=8: send 40 bytes (10 words, last nbytes=4).
  - len_ovf=1 once len exceeds 255.
  - LEN_LO reports 0x000000FF (saturated).

Source files
------------

// File: rtl/sha256_msg_pad.sv
// Streaming SHA-256 message padder: 32-bit message words in, 512-bit blocks out as 16 big-endian words.
// Optional build macro SHA256_PAD_BSWAP_EN: treat in_data as little-endian and byte-swap each word.
module sha256_msg_pad #(
   parameter int LEN_W     = 64,
   parameter int BLK_CNT_W = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_vld,
   output logic                 in_rdy,
   input  logic [31:0]          in_data,
   input  logic                 in_last,
   input  logic [2:0]           in_nbytes,
   output logic                 out_vld,
   input  logic                 out_rdy,
   output logic [31:0]          out_data,
   output logic                 out_blk_first,
   output logic                 out_blk_last,
   output logic                 out_msg_last,
   output logic [BLK_CNT_W-1:0] blk_cnt,
   output logic                 len_ovf
);

   typedef enum logic [2:0] {
      ST_DATA   = 3'd0,
      ST_PAD80  = 3'd1,
      ST_ZERO   = 3'd2,
      ST_LEN_HI = 3'd3,
      ST_LEN_LO = 3'd4
   } state_t;

   state_t               state_r, nxt_state_s, pad_next_s;
   logic [3:0]           idx_r, idx_inc_s;
   logic [LEN_W-1:0]     len_r;
   logic [LEN_W:0]       len_sum_s;
   logic [63:0]          len64_s;
   logic [31:0]          word_in_s, word_s;
   logic [2:0]           nbytes_s;
   logic                 adv_s, emit_s, load_s, take_s, consume_last_s;
   logic [BLK_CNT_W-1:0] blk_base_s, blk_nxt_s;

   // Keep bytes below n, put the 0x80 marker in byte n, zero the rest; n=4 passes the word through.
   function automatic logic [31:0] pad_word(input logic [31:0] w, input logic [2:0] n);
      case (n)
         3'd0:    pad_word = 32'h8000_0000;
         3'd1:    pad_word = {w[31:24], 24'h80_0000};
         3'd2:    pad_word = {w[31:16], 16'h8000};
         3'd3:    pad_word = {w[31:8], 8'h80};
         default: pad_word = w;
      endcase
   endfunction

`ifdef SHA256_PAD_BSWAP_EN
   assign word_in_s = {in_data[7:0], in_data[15:8], in_data[23:16], in_data[31:24]};
`else
   assign word_in_s = in_data;
`endif

   assign adv_s          = !out_vld | out_rdy;
   assign in_rdy         = (state_r == ST_DATA) & adv_s;
   assign take_s         = in_vld & in_rdy;
   assign load_s         = adv_s & emit_s;
   assign idx_inc_s      = idx_r + 4'd1;
   assign nbytes_s       = (!in_last || (in_nbytes > 3'd4)) ? 3'd4 : in_nbytes;
   assign len_sum_s      = {1'b0, len_r} + (LEN_W+1)'({nbytes_s, 3'b000});
   assign len64_s        = 64'(len_r);
   assign consume_last_s = out_vld & out_rdy & out_msg_last;
   assign pad_next_s     = (idx_inc_s == 4'd14) ? ST_LEN_HI : ST_ZERO;

   // Next output word and state for whatever the current state would emit.
   always_comb begin
      word_s      = 32'h0000_0000;
      nxt_state_s = state_r;
      emit_s      = 1'b0;
      case (state_r)
         ST_DATA: begin
            emit_s = in_vld;
            word_s = pad_word(word_in_s, nbytes_s);
            if (!in_last) begin
               nxt_state_s = ST_DATA;
            end else if (nbytes_s == 3'd4) begin
               nxt_state_s = ST_PAD80;
            end else begin
               nxt_state_s = pad_next_s;
            end
         end
         ST_PAD80: begin
            emit_s      = 1'b1;
            word_s      = 32'h8000_0000;
            nxt_state_s = pad_next_s;
         end
         ST_ZERO: begin
            emit_s      = 1'b1;
            word_s      = 32'h0000_0000;
            nxt_state_s = pad_next_s;
         end
         ST_LEN_HI: begin
            emit_s      = 1'b1;
            word_s      = len64_s[63:32];
            nxt_state_s = ST_LEN_LO;
         end
         ST_LEN_LO: begin
            emit_s      = 1'b1;
            word_s      = len64_s[31:0];
            nxt_state_s = ST_DATA;
         end
         default: begin
            emit_s      = 1'b0;
            nxt_state_s = ST_DATA;
         end
      endcase
   end

   // Block counter stays visible alongside the final word and clears once that word is taken.
   always_comb begin
      blk_base_s = consume_last_s ? {BLK_CNT_W{1'b0}} : blk_cnt;
      if (load_s && (idx_r == 4'd15) && (blk_base_s != {BLK_CNT_W{1'b1}})) begin
         blk_nxt_s = blk_base_s + {{(BLK_CNT_W-1){1'b0}}, 1'b1};
      end else begin
         blk_nxt_s = blk_base_s;
      end
   end

   // State, length accumulator and output register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r       <= ST_DATA;
         idx_r         <= 4'd0;
         len_r         <= {LEN_W{1'b0}};
         blk_cnt       <= {BLK_CNT_W{1'b0}};
         len_ovf       <= 1'b0;
         out_vld       <= 1'b0;
         out_data      <= 32'h0000_0000;
         out_blk_first <= 1'b0;
         out_blk_last  <= 1'b0;
         out_msg_last  <= 1'b0;
      end else begin
         blk_cnt <= blk_nxt_s;
         if (take_s) begin
            if (len_sum_s[LEN_W]) begin
               len_r   <= {LEN_W{1'b1}};
               len_ovf <= 1'b1;
            end else begin
               len_r <= len_sum_s[LEN_W-1:0];
            end
         end else if (load_s && (state_r == ST_LEN_LO)) begin
            len_r <= {LEN_W{1'b0}};
         end
         if (adv_s) begin
            out_vld <= emit_s;
            if (emit_s) begin
               out_data      <= word_s;
               out_blk_first <= (idx_r == 4'd0);
               out_blk_last  <= (idx_r == 4'd15);
               out_msg_last  <= (state_r == ST_LEN_LO);
               idx_r         <= idx_inc_s;
               state_r       <= nxt_state_s;
            end
         end
      end
   end

endmodule
